// File: rtl/frame_gen_pkg.sv
// rtl/frame_gen_pkg.sv - shared types and constants for the frame_gen video timing generator
// State encoding and the minimum values applied to the size/blanking inputs.
package frame_gen_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FBLANK = 3'd1,
    VPRE   = 3'd2,
    LINE   = 3'd3,
    HBLANK = 3'd4
  } state_t;

  localparam int HS_MIN = 1;
  localparam int VS_MIN = 1;
  localparam int HB_MIN = 1;
  localparam int FB_MIN = 1;

endpackage

// File: rtl/frame_gen_if.sv
// rtl/frame_gen_if.sv - fvalid/lvalid/dvalid video stream interface
// The pixel bus and DATA_BITS exist only when FRAME_GEN_TESTPAT_EN is defined.
interface frame_gen_if
`ifdef FRAME_GEN_TESTPAT_EN
  #(parameter int DATA_BITS = 16)
`endif
  ;

  logic fvalid;
  logic lvalid;
  logic dvalid;
  logic frame_start;
  logic line_start;
`ifdef FRAME_GEN_TESTPAT_EN
  logic [DATA_BITS-1:0] pixel;
`endif

  modport master (
    output fvalid, lvalid, dvalid, frame_start,
`ifdef FRAME_GEN_TESTPAT_EN
    output pixel,
`endif
    output line_start
  );

  modport slave (
    input fvalid, lvalid, dvalid, frame_start,
`ifdef FRAME_GEN_TESTPAT_EN
    input pixel,
`endif
    input line_start
  );

endinterface

// File: rtl/frame_gen_testpat.sv
// rtl/frame_gen_testpat.sv - (x + y) test pattern, aligned with the registered dvalid
// Driven by the generator's next-state decode so pixel lands on the same edge as dvalid.
module frame_gen_testpat #(
  parameter int TIMER_BITS = 32,
  parameter int DATA_BITS  = 16
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 i_active_next,
  input  logic                 i_frame_idle,
  output logic [DATA_BITS-1:0] o_pixel
);

  logic [TIMER_BITS-1:0] r_x;
  logic [TIMER_BITS-1:0] r_y;
  logic [DATA_BITS-1:0]  r_pixel;
  logic [TIMER_BITS-1:0] w_sum;

  assign w_sum   = r_x + r_y;
  assign o_pixel = r_pixel;

  // A non-zero column count while inactive means a line just ended: advance y once.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_pixel <= '0;
    end else if (i_active_next) begin
      r_pixel <= DATA_BITS'(w_sum);
      r_x     <= r_x + TIMER_BITS'(1);
    end else begin
      r_pixel <= '0;
      r_x     <= '0;
      if (i_frame_idle) begin
        r_y <= '0;
      end else if (r_x != '0) begin
        r_y <= r_y + TIMER_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/frame_gen.sv
// rtl/frame_gen.sv - programmable fvalid/lvalid/dvalid raster timing generator
// FRAME_GEN_TESTPAT_EN adds the DATA_BITS parameter and an (x + y) pixel output.
module frame_gen
  import frame_gen_pkg::*;
#(
  parameter int TIMER_BITS = 32
`ifdef FRAME_GEN_TESTPAT_EN
  , parameter int DATA_BITS = 16
`endif
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [TIMER_BITS-1:0] hsize,
  input  logic [TIMER_BITS-1:0] vsize,
  input  logic [TIMER_BITS-1:0] hblank,
  input  logic [TIMER_BITS-1:0] vblank,
  input  logic [TIMER_BITS-1:0] fblank,
  output logic                  busy,
  frame_gen_if.master           vid
);

  localparam logic [TIMER_BITS-1:0] ONE = TIMER_BITS'(1);

  state_t                r_state;
  state_t                w_next;
  logic [TIMER_BITS-1:0] r_hs, r_vs, r_hb, r_vb, r_fb;
  logic [TIMER_BITS-1:0] r_cnt, r_line;
  logic [TIMER_BITS-1:0] w_cnt_next, w_line_next;
  logic                  w_capture;
  logic                  r_fvalid, r_lvalid, r_frame_start, r_line_start, r_busy;

  always_comb begin
    w_next      = r_state;
    w_cnt_next  = r_cnt + ONE;
    w_line_next = r_line;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (enable) begin
          w_next    = FBLANK;
          w_capture = 1'b1;
        end
      end
      FBLANK: if (r_cnt == r_fb - ONE) begin
        w_cnt_next  = '0;
        w_line_next = '0;
        w_next      = (r_vb == '0) ? LINE : VPRE;
      end
      VPRE: if (r_cnt == r_vb - ONE) begin
        w_cnt_next = '0;
        w_next     = LINE;
      end
      LINE: if (r_cnt == r_hs - ONE) begin
        w_cnt_next = '0;
        // enable is consulted only here, so a started frame always completes
        if (r_line == r_vs - ONE) begin
          w_next    = enable ? FBLANK : IDLE;
          w_capture = enable;
        end else begin
          w_next      = HBLANK;
          w_line_next = r_line + ONE;
        end
      end
      HBLANK: if (r_cnt == r_hb - ONE) begin
        w_cnt_next = '0;
        w_next     = LINE;
      end
      default: begin
        w_next     = IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_line        <= '0;
      r_hs          <= '0;
      r_vs          <= '0;
      r_hb          <= '0;
      r_vb          <= '0;
      r_fb          <= '0;
      r_fvalid      <= 1'b0;
      r_lvalid      <= 1'b0;
      r_frame_start <= 1'b0;
      r_line_start  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_cnt         <= w_cnt_next;
      r_line        <= w_line_next;
      r_fvalid      <= (w_next == VPRE) || (w_next == LINE) || (w_next == HBLANK);
      r_lvalid      <= (w_next == LINE);
      r_frame_start <= (r_state == FBLANK) && (w_next != FBLANK);
      r_line_start  <= (w_next == LINE) && (r_state != LINE);
      r_busy        <= (w_next != IDLE);
      if (w_capture) begin
        r_hs <= (hsize  < TIMER_BITS'(HS_MIN)) ? TIMER_BITS'(HS_MIN) : hsize;
        r_vs <= (vsize  < TIMER_BITS'(VS_MIN)) ? TIMER_BITS'(VS_MIN) : vsize;
        r_hb <= (hblank < TIMER_BITS'(HB_MIN)) ? TIMER_BITS'(HB_MIN) : hblank;
        r_fb <= (fblank < TIMER_BITS'(FB_MIN)) ? TIMER_BITS'(FB_MIN) : fblank;
        r_vb <= vblank;
      end
    end
  end

  assign vid.fvalid      = r_fvalid;
  assign vid.lvalid      = r_lvalid;
  assign vid.dvalid      = r_lvalid;
  assign vid.frame_start = r_frame_start;
  assign vid.line_start  = r_line_start;
  assign busy            = r_busy;

`ifdef FRAME_GEN_TESTPAT_EN
  frame_gen_testpat #(
    .TIMER_BITS (TIMER_BITS),
    .DATA_BITS  (DATA_BITS)
  ) u_testpat (
    .clk_in        (clk_in),
    .reset         (reset),
    .i_active_next (w_next == LINE),
    .i_frame_idle  ((w_next == IDLE) || (w_next == FBLANK)),
    .o_pixel       (vid.pixel)
  );
`endif

endmodule

// File: doc/frame_gen.md
Name: frame_gen

Overview:
Programmable video timing generator. Produces fvalid/lvalid/dvalid strobes for a raster whose line size, line count, horizontal blanking, pre-line vertical blanking and inter-frame blanking come from input registers. It is the source side of the fvalid/lvalid/dvalid video interface used across the codebase. It drives test sources, loopback benches, and downstream line/frame buffers.

Parameters:
TIMER_BITS, 32, width of all size/blanking inputs and internal counters
DATA_BITS, 16, test-pattern pixel width (used only with FRAME_GEN_TESTPAT_EN)

Ports:
clk_in  in  1  sole clock
reset  in  1  synchronous, active-high reset
enable  in  1  level; 1 = generate frames, 0 = stop at next frame boundary
hsize  in  TIMER_BITS  active clocks per line
vsize  in  TIMER_BITS  lines per frame
hblank  in  TIMER_BITS  clocks with lvalid=0 between lines, fvalid=1
vblank  in  TIMER_BITS  clocks with fvalid=1 before the first line
fblank  in  TIMER_BITS  clocks with fvalid=0 between frames
fvalid  out  1  frame valid
lvalid  out  1  line valid
dvalid  out  1  data valid; equals lvalid
frame_start  out  1  one-cycle pulse on the first fvalid=1 cycle
line_start  out  1  one-cycle pulse on the first lvalid=1 cycle of each line
busy  out  1  1 whenever state != IDLE

Behaviour:
- Clock and reset: one clock, clk_in. reset is synchronous and active-high.
- Reset: state=IDLE; fvalid, lvalid, dvalid, frame_start, line_start, busy and pixel all 0; counters 0. Reset mid-frame drops all strobes on the next edge with no frame completion.
- States: IDLE, FBLANK, VPRE, LINE, HBLANK. All outputs are registered and decoded from the state.
  - IDLE: all strobes 0. enable=1 -> FBLANK.
  - FBLANK: fvalid=0. Lasts fb cycles -> VPRE, or LINE if vb=0.
  - VPRE: fvalid=1, lvalid=0. Lasts vb cycles -> LINE.
  - LINE: fvalid=lvalid=dvalid=1. Lasts hs cycles. If this is the last line -> FBLANK (enable=1) or IDLE (enable=0). Otherwise -> HBLANK.
  - HBLANK: fvalid=1, lvalid=0. Lasts hb cycles -> LINE.
- Shadowing: hsize, vsize, hblank, vblank and fblank are captured into shadow registers on every transition into FBLANK. Mid-frame input changes take effect at the next frame.
- Clamping: hs=max(hsize,1), vs=max(vsize,1), hb=max(hblank,1), fb=max(fblank,1), vb=vblank (0 allowed).
  - fb minimum 1 guarantees an fvalid falling edge between frames.
  - hb minimum 1 guarantees an lvalid falling edge between lines.
- Frame end: on the last line, fvalid and lvalid fall on the same edge.
- Frame period: fb + vb + vs*hs + (vs-1)*hb clocks.
- Latency: enable sampled 1 at edge N -> FBLANK from N+1 -> first fvalid=1 at edge N+1+fb.
- Enable: deassertion is graceful. The current frame always completes. Only the decision at the end of the last line consults enable. Deassertion during FBLANK/VPRE still completes that frame.
- Counters: a cycle counter counts up and terminates at (value-1) of the current phase. A line counter counts 0..vs-1. Both are TIMER_BITS wide and have no wrap in legal use. Full-range values (2^TIMER_BITS-1) must work.
- Pulses: frame_start is high on the first VPRE cycle, or on the first LINE cycle if vb=0. line_start is high on the first cycle of every LINE.

Optional Feature:
FRAME_GEN_TESTPAT_EN
- Defined: adds output pixel [DATA_BITS-1:0], registered and aligned with dvalid, with value (x + y) mod 2^DATA_BITS.
  - x = column index within the line (0..hs-1); y = line index (0..vs-1).
  - pixel is 0 whenever dvalid=0.
- Undefined: the pixel port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package frame_gen_pkg: state enum (IDLE, FBLANK, VPRE, LINE, HBLANK); minimum-value constants HS_MIN=1, VS_MIN=1, HB_MIN=1, FB_MIN=1.
- One natural sub-module: frame_gen_testpat (x/y counters and pixel adder), instantiated only under FRAME_GEN_TESTPAT_EN.

Test Plan:
- Basic raster: hsize=4, vsize=3, hblank=2, vblank=5, fblank=3, enable held 1 -> per frame fvalid low 3, high 21; three lvalid runs of 4 separated by 2 low; period 24; frame_start once per frame, line_start 3 times.
- Zero clamps: hsize=0, vsize=0, hblank=0, fblank=0, vblank=0 -> 1-line frames of 1 data clock, fvalid low 1 cycle, period 2; lvalid rises together with fvalid.
- Shadowing: change hsize 4->8 in the middle of line 2 -> the current frame keeps 4-clock lines; the next frame uses 8.
- Graceful stop: drop enable in the middle of line 1 with vsize=3 -> lines 2-3 complete, fvalid falls with the last lvalid, IDLE and busy=0 next cycle, no further fvalid.
- Reset mid-line: assert reset for 1 cycle during LINE -> all outputs 0 on the next edge; with enable=1 the next fvalid rises fb+1 cycles after reset release.
- TESTPAT_EN build, hsize=4, vsize=2 -> pixel sequence 0,1,2,3 then 1,2,3,4; 0 whenever dvalid=0.
